// File: rtl/traffic_pkg.sv
// Shared light codes, direction indices and scheduler state encoding.
package traffic_pkg;

  localparam int unsigned NUM_DIR = 4;
  localparam int unsigned DIR_W   = 2;
  localparam int unsigned LIGHT_W = 2;

  localparam logic [LIGHT_W-1:0] LIGHT_RED    = 2'b00;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 2'b10;

  localparam logic [DIR_W-1:0] DIR_N = 2'd0;
  localparam logic [DIR_W-1:0] DIR_E = 2'd1;
  localparam logic [DIR_W-1:0] DIR_S = 2'd2;
  localparam logic [DIR_W-1:0] DIR_WEST = 2'd3;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ALLRED = 2'd1,
    ST_GREEN  = 2'd2,
    ST_YELLOW = 2'd3
  } state_e;

  // One light code per approach, indexed by direction.
  typedef logic [NUM_DIR-1:0][LIGHT_W-1:0] lights_t;

  // One-hot mask for a direction index.
  function automatic logic [NUM_DIR-1:0] dir_onehot(input logic [DIR_W-1:0] d);
    return NUM_DIR'(1) << d;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_tick_gen.sv
// Free-running divider producing a one-cycle timing tick every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Wrap to zero on the tick cycle, otherwise count up.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven round-robin phase scheduler for a four-approach intersection
// with min/max green, fixed yellow and all-red clearance, and emergency preemption.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 9,
  parameter int unsigned YELLOW_T  = 1,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_DIR-1:0]   req,
  input  logic                 emerg_valid,
  input  logic [DIR_W-1:0]     emerg_dir,
  output logic [LIGHT_W-1:0]   north,
  output logic [LIGHT_W-1:0]   east,
  output logic [LIGHT_W-1:0]   south,
  output logic [LIGHT_W-1:0]   west,
  output logic [NUM_DIR-1:0]   grant,
  output logic [DIR_W-1:0]     active_dir
);

  localparam int unsigned PH_MAX_A = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
  localparam int unsigned PH_MAX   = (PH_MAX_A > ALLRED_T) ? PH_MAX_A : ALLRED_T;
  localparam int unsigned PH_W     = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] PH_MIN_G  = PH_W'(MIN_GREEN - 1);
  localparam logic [PH_W-1:0] PH_MAX_G  = PH_W'(MAX_GREEN - 1);
  localparam logic [PH_W-1:0] PH_YELLOW = PH_W'(YELLOW_T - 1);
  localparam logic [PH_W-1:0] PH_ALLRED = PH_W'(ALLRED_T - 1);

  // Round-robin pick: first requesting approach at last+1, +2, +3, then last.
  function automatic logic [DIR_W:0] rr_pick(input logic [NUM_DIR-1:0] r,
                                             input logic [DIR_W-1:0]   last);
    logic [DIR_W:0]   res;
    logic [DIR_W-1:0] idx;
    res = '0;
    for (int k = NUM_DIR; k >= 1; k--) begin
      idx = last + DIR_W'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  logic tick;

  state_e             state_q, state_d;
  logic [DIR_W-1:0]   active_q, active_d;
  logic [DIR_W-1:0]   last_q, last_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  lights_t            lights_q, lights_d;
  logic [NUM_DIR-1:0] grant_q, grant_d;

  logic [DIR_W:0]     sel;
  logic               emerg_here;
  logic               preempt;
  logic               gap_out;
  logic               max_out;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Next-approach selection and green-exit conditions.
  always_comb begin
    sel        = emerg_valid ? {1'b1, emerg_dir} : rr_pick(req, last_q);
    emerg_here = emerg_valid && (emerg_dir == active_q);
    preempt    = emerg_valid && (emerg_dir != active_q);
    gap_out    = (phase_q >= PH_MIN_G) && !req[active_q] && !emerg_here;
    max_out    = (phase_q >= PH_MAX_G) && |(req & ~dir_onehot(active_q)) && !emerg_here;
  end

  // Phase sequencing; state only advances on tick cycles.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    last_d   = last_q;
    phase_d  = phase_q;
    if (tick) begin
      unique case (state_q)
        ST_INIT: begin
          state_d = ST_ALLRED;
          phase_d = '0;
        end
        ST_ALLRED: begin
          if (phase_q == PH_ALLRED) begin
            if (sel[DIR_W]) begin
              state_d  = ST_GREEN;
              active_d = sel[DIR_W-1:0];
              phase_d  = '0;
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        ST_GREEN: begin
          if (preempt || gap_out || max_out) begin
            state_d = ST_YELLOW;
            phase_d = '0;
          end else if (phase_q != PH_MAX_G) begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        ST_YELLOW: begin
          if (phase_q == PH_YELLOW) begin
            state_d = ST_ALLRED;
            last_d  = active_q;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        default: begin
          state_d = ST_INIT;
          phase_d = '0;
        end
      endcase
    end
  end

  // Light and grant decode of the next state, registered alongside it.
  always_comb begin
    lights_d = {NUM_DIR{LIGHT_RED}};
    grant_d  = '0;
    unique case (state_d)
      ST_INIT:   lights_d = {NUM_DIR{LIGHT_YELLOW}};
      ST_GREEN: begin
        lights_d[active_d] = LIGHT_GREEN;
        grant_d            = dir_onehot(active_d);
      end
      ST_YELLOW: lights_d[active_d] = LIGHT_YELLOW;
      default:   lights_d = {NUM_DIR{LIGHT_RED}};
    endcase
  end

  // State, direction, phase timer and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      active_q <= DIR_N;
      last_q   <= DIR_WEST;
      phase_q  <= '0;
      lights_q <= {NUM_DIR{LIGHT_YELLOW}};
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      last_q   <= last_d;
      phase_q  <= phase_d;
      lights_q <= lights_d;
      grant_q  <= grant_d;
    end
  end

  assign north      = lights_q[DIR_N];
  assign east       = lights_q[DIR_E];
  assign south      = lights_q[DIR_S];
  assign west       = lights_q[DIR_WEST];
  assign grant      = grant_q;
  assign active_dir = active_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with a 4-cycle tick.
module tb_traffic_phase_scheduler;

  // Packed observation: {north, east, south, west, grant, active_dir}
  localparam logic [13:0] INIT_V = 14'b01_01_01_01_0000_00;
  localparam logic [13:0] AR0    = 14'b00_00_00_00_0000_00;
  localparam logic [13:0] AR1    = 14'b00_00_00_00_0000_01;
  localparam logic [13:0] AR3    = 14'b00_00_00_00_0000_11;
  localparam logic [13:0] NG     = 14'b10_00_00_00_0001_00;
  localparam logic [13:0] NY     = 14'b01_00_00_00_0000_00;
  localparam logic [13:0] EG     = 14'b00_10_00_00_0010_01;
  localparam logic [13:0] EY     = 14'b00_01_00_00_0000_01;
  localparam logic [13:0] WG     = 14'b00_00_00_10_1000_11;
  localparam logic [13:0] WY     = 14'b00_00_00_01_0000_11;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       emerg_valid;
  logic [1:0] emerg_dir;
  logic [1:0] north, east, south, west;
  logic [3:0] grant;
  logic [1:0] active_dir;
  logic [13:0] obs;

  int edges;
  int vectors;
  int miscompares;

  traffic_phase_scheduler #(
    .TICK_DIV  (4),
    .MIN_GREEN (2),
    .MAX_GREEN (4),
    .YELLOW_T  (1),
    .ALLRED_T  (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .emerg_valid (emerg_valid),
    .emerg_dir   (emerg_dir),
    .north       (north),
    .east        (east),
    .south       (south),
    .west        (west),
    .grant       (grant),
    .active_dir  (active_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {north, east, south, west, grant, active_dir};

  // Number of rising edges since reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic do_reset(input logic [3:0] r);
    reset       = 1'b0;
    req         = r;
    emerg_valid = 1'b0;
    emerg_dir   = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Advance to the falling edge where exactly e rising edges have elapsed.
  task automatic run_to(input int e);
    int guard;
    guard = 0;
    while (edges < e && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (edges != e) begin
      vectors++;
      miscompares++;
      $display("FAIL run_to: reached edge %0d, wanted %0d", edges, e);
    end
  endtask

  task automatic test_reset;
    int          ev [5] = '{1, 3, 4, 7, 20};
    logic [13:0] xv [5] = '{INIT_V, INIT_V, AR0, AR0, AR0};
    do_reset(4'b0000);
    for (int i = 0; i < 5; i++) begin
      run_to(ev[i]);
      vectors++;
      if (obs !== xv[i]) begin
        miscompares++;
        $display("FAIL reset_idle@%0d: got %b want %b", ev[i], obs, xv[i]);
      end
    end
  endtask

  task automatic test_single_rest;
    int          ev [4] = '{7, 8, 100, 208};
    logic [13:0] xv [4] = '{AR0, NG, NG, NG};
    do_reset(4'b0001);
    for (int i = 0; i < 4; i++) begin
      run_to(ev[i]);
      vectors++;
      if (obs !== xv[i]) begin
        miscompares++;
        $display("FAIL single_rest@%0d: got %b want %b", ev[i], obs, xv[i]);
      end
    end
  endtask

  task automatic test_max_out;
    int          ev [7] = '{8, 23, 24, 27, 28, 31, 32};
    logic [13:0] xv [7] = '{NG, NG, NY, NY, AR0, AR0, EG};
    do_reset(4'b0011);
    for (int i = 0; i < 7; i++) begin
      run_to(ev[i]);
      vectors++;
      if (obs !== xv[i]) begin
        miscompares++;
        $display("FAIL max_out@%0d: got %b want %b", ev[i], obs, xv[i]);
      end
    end
  endtask

  task automatic test_gap_out;
    int          ev [4] = '{15, 16, 20, 40};
    logic [13:0] xv [4] = '{NG, NY, AR0, AR0};
    do_reset(4'b0001);
    run_to(12);
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      run_to(ev[i]);
      vectors++;
      if (obs !== xv[i]) begin
        miscompares++;
        $display("FAIL gap_out@%0d: got %b want %b", ev[i], obs, xv[i]);
      end
    end
  endtask

  task automatic test_preempt;
    int          ev [11] = '{8, 12, 15, 16, 20, 24, 28, 44, 47, 48, 52};
    logic [13:0] xv [11] = '{EG, EG, EG, EY, AR1, WG, WG, WG, WG, WY, AR3};
    do_reset(4'b0010);
    for (int i = 0; i < 11; i++) begin
      run_to(ev[i]);
      if (ev[i] == 12) begin
        emerg_valid = 1'b1;
        emerg_dir   = 2'd3;
      end
      if (ev[i] == 24) req = 4'b1111;
      if (ev[i] == 44) emerg_valid = 1'b0;
      vectors++;
      if (obs !== xv[i]) begin
        miscompares++;
        $display("FAIL preempt@%0d: got %b want %b", ev[i], obs, xv[i]);
      end
    end
    run_to(56);
    vectors++;
    if (obs !== NG) begin
      miscompares++;
      $display("FAIL preempt_rr_wrap@56: got %b want %b", obs, NG);
    end
  endtask

  task automatic test_reset_mid_green;
    int          ev [3] = '{3, 4, 8};
    logic [13:0] xv [3] = '{INIT_V, AR0, NG};
    do_reset(4'b0001);
    run_to(10);
    vectors++;
    if (obs !== NG) begin
      miscompares++;
      $display("FAIL pre_reset_green: got %b want %b", obs, NG);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (obs !== INIT_V) begin
      miscompares++;
      $display("FAIL async_reset: got %b want %b", obs, INIT_V);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_to(ev[i]);
      vectors++;
      if (obs !== xv[i]) begin
        miscompares++;
        $display("FAIL restart@%0d: got %b want %b", ev[i], obs, xv[i]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_rest();
    test_max_out();
    test_gap_out();
    test_preempt();
    test_reset_mid_green();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
